// File: rtl/pipe_stage_reg.sv
// Pipeline register between datapath stages: STAGES slots with valid, ctrl and data.
// Optional stall/flush performance counters: define PIPE_REG_PERF_EN.
module pipe_stage_reg #(
    parameter int               CTRL_W    = 16,
    parameter int               DATA_W    = 128,
    parameter int               STAGES    = 1,
    parameter logic [CTRL_W-1:0] CTRL_SAFE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("pipe_stage_reg: STAGES must be 1..4");
        end
    endgenerate

    logic              valid_q [STAGES];
    logic [CTRL_W-1:0] ctrl_q  [STAGES];
    logic [DATA_W-1:0] data_q  [STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                ctrl_q[k]  <= CTRL_SAFE;
                data_q[k]  <= '0;
            end
        end else if (flush) begin
            // data keeps moving; only control is killed
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                ctrl_q[k]  <= CTRL_SAFE;
            end
            data_q[0] <= in_data;
            for (int k = 1; k < STAGES; k++) begin
                data_q[k] <= data_q[k-1];
            end
        end else if (!stall) begin
            valid_q[0] <= in_valid;
            ctrl_q[0]  <= in_valid ? in_ctrl : CTRL_SAFE;
            data_q[0]  <= in_data;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                ctrl_q[k]  <= ctrl_q[k-1];
                data_q[k]  <= data_q[k-1];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_ctrl  = ctrl_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

`ifdef PIPE_REG_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // saturating counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (flush && flush_q != '1) begin
                flush_q <= flush_q + 1'b1;
            end
            if (stall && !flush && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised bench for pipe_stage_reg: STAGES=1 and STAGES=3 (CNT_W=2)
// instances driven in lockstep and checked against a queue model.
module tb_pipe_stage_reg;

    localparam logic [15:0] SAFE1 = 16'h0000;
    localparam logic [15:0] SAFE3 = 16'h0013;

    typedef struct packed {
        logic         v;
        logic [15:0]  c;
        logic [127:0] d;
    } slot_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall;
    logic         flush;
    logic         in_valid;
    logic [15:0]  in_ctrl;
    logic [127:0] in_data;

    logic         v1, v3;
    logic [15:0]  c1, c3;
    logic [127:0] d1, d3;
    logic [15:0]  sc1, fc1;
    logic [1:0]   sc3, fc3;

    int checks = 0;
    int errors = 0;

    slot_t q1[$];
    slot_t q3[$];
    int    m_stall = 0;
    int    m_flush = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W(16), .DATA_W(128), .STAGES(1),
        .CTRL_SAFE(SAFE1), .CNT_W(16)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v1), .out_ctrl(c1), .out_data(d1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    pipe_stage_reg #(
        .CTRL_W(16), .DATA_W(128), .STAGES(3),
        .CTRL_SAFE(SAFE3), .CNT_W(2)
    ) u3 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(v3), .out_ctrl(c3), .out_data(d3),
        .stall_cnt(sc3), .flush_cnt(fc3)
    );

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pipe contents as a queue: front is slot 0, back is the output slot.
    task automatic mstep(ref slot_t q[$], input int n,
                         input logic [15:0] safe);
        slot_t s;
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < n; i++) q.push_back({1'b0, safe, 128'd0});
        end else if (flush) begin
            q.push_front({1'b0, safe, in_data});
            void'(q.pop_back());
            for (int i = 0; i < n; i++) begin
                s = q[i];
                s.v = 1'b0;
                s.c = safe;
                q[i] = s;
            end
        end else if (!stall) begin
            q.push_front({in_valid, in_valid ? in_ctrl : safe, in_data});
            void'(q.pop_back());
        end
    endtask

    function automatic int sat(input int x, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic cycle(input logic r, input logic f, input logic s,
                         input logic v, input logic [15:0] c,
                         input logic [127:0] d);
        slot_t o1, o3;
        int e1s, e1f, e3s, e3f;
        rst_n = r; flush = f; stall = s;
        in_valid = v; in_ctrl = c; in_data = d;
        @(posedge clk);
        mstep(q1, 1, SAFE1);
        mstep(q3, 3, SAFE3);
        if (!rst_n) begin
            m_stall = 0;
            m_flush = 0;
        end else if (flush) begin
            m_flush++;
        end else if (stall) begin
            m_stall++;
        end
        #1;
        o1 = q1[0];
        o3 = q3[2];
`ifdef PIPE_REG_PERF_EN
        e1s = sat(m_stall, 16); e1f = sat(m_flush, 16);
        e3s = sat(m_stall, 2);  e3f = sat(m_flush, 2);
`else
        e1s = 0; e1f = 0; e3s = 0; e3f = 0;
`endif
        chk("s1_valid", 128'(v1), 128'(o1.v));
        chk("s1_ctrl",  128'(c1), 128'(o1.c));
        chk("s1_data",  d1,       o1.d);
        chk("s1_stall_cnt", 128'(sc1), 128'(e1s));
        chk("s1_flush_cnt", 128'(fc1), 128'(e1f));
        chk("s3_valid", 128'(v3), 128'(o3.v));
        chk("s3_ctrl",  128'(c3), 128'(o3.c));
        chk("s3_data",  d3,       o3.d);
        chk("s3_stall_cnt", 128'(sc3), 128'(e3s));
        chk("s3_flush_cnt", 128'(fc3), 128'(e3f));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_ctrl = '0; in_data = '0;

        // reset with live inputs present
        cycle(0, 0, 0, 1, 16'hFFFF, rnd128());
        cycle(0, 1, 1, 1, 16'hFFFF, rnd128());

        // streaming
        cycle(1, 0, 0, 1, 16'h0011, 128'hA1);
        cycle(1, 0, 0, 1, 16'h0022, 128'hA2);
        // stall while inputs change
        for (int i = 0; i < 3; i++)
            cycle(1, 0, 1, 1, 16'h0100 + 16'(i), rnd128());
        cycle(1, 0, 0, 1, 16'h0033, 128'hA3);

        // flush and stall together
        cycle(1, 1, 1, 1, 16'h00FF, rnd128());
        // bubble gating
        cycle(1, 0, 0, 0, 16'hBEEF, rnd128());

        // three live items then flush
        cycle(1, 0, 0, 1, 16'h0041, rnd128());
        cycle(1, 0, 0, 1, 16'h0042, rnd128());
        cycle(1, 0, 0, 1, 16'h0043, rnd128());
        cycle(1, 1, 0, 1, 16'h0044, rnd128());
        for (int i = 0; i < 3; i++)
            cycle(1, 0, 0, 0, 16'h0000, rnd128());

        // long stall drives the narrow counter into saturation
        cycle(1, 0, 0, 1, 16'h0055, rnd128());
        for (int i = 0; i < 5; i++)
            cycle(1, 0, 1, 1, 16'h0066, rnd128());
        for (int i = 0; i < 4; i++)
            cycle(1, 1, 0, 1, 16'h0077, rnd128());

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) >= 3,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 70,
                  16'($urandom()), rnd128());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the 5-stage datapath. It generalises the fixed-field stage latches into a control/data-split register of configurable width and latency (STAGES slots). It adds a per-slot valid bit, reset, stall-hold, and flush-to-bubble behaviour. It instantiates between IF/ID, ID/EX, EX/MEM and MEM/WB, with control fields driven onto ctrl and operands/addresses onto data.

Parameters:
CTRL_W, 16, width of control field; it is forced to a safe value on flush, bubble and reset.
DATA_W, 128, width of data/operand field; it is not cleared on flush.
STAGES, 1, number of chained register slots (1..4), which equals latency in cycles.
CTRL_SAFE, 0, CTRL_W-bit value loaded into control on reset, flush or bubble.
CNT_W, 16, width of performance counters (used only with PIPE_REG_PERF_EN).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; one clock, reset is synchronous and active-low
stall  input  1  hold all slots unchanged this cycle
flush  input  1  kill all in-flight slots and insert bubbles
in_valid  input  1  upstream stage holds a real instruction
in_ctrl  input  CTRL_W  upstream control field
in_data  input  DATA_W  upstream data field (PC, operands, imm, rs/rt/rd)
out_valid  output  1  valid bit of last slot
out_ctrl  output  CTRL_W  control field of last slot
out_data  output  DATA_W  data field of last slot
stall_cnt  output  CNT_W  cycles with stall asserted (PIPE_REG_PERF_EN only)
flush_cnt  output  CNT_W  cycles with flush asserted (PIPE_REG_PERF_EN only)

Behaviour:
- All outputs are registered. There is no combinational path from input to output.
- Each slot k (0..STAGES-1) holds valid[k], ctrl[k] and data[k]. Slot 0 is fed from the inputs, slot k from slot k-1, and the outputs come from slot STAGES-1.
- Update priority per rising clk edge: rst_n low > flush > stall > normal.
- Reset (rst_n=0 at the edge):
  - every valid is set to 0, every ctrl to CTRL_SAFE, every data to 0.
  - counters are set to 0.
  - Reset overrides a simultaneous stall or flush.
  - Reset mid-stream discards all in-flight slots. The first post-reset output is a bubble.
- Flush (rst_n=1, flush=1):
  - every valid is set to 0 and every ctrl to CTRL_SAFE.
  - data shifts normally (slot0 <= in_data, slot k <= slot k-1). Data is don't-care for bubbles.
  - Flush wins over a simultaneous stall.
- Stall (flush=0, stall=1): every valid, ctrl and data register holds its value, and in_* is ignored.
- Normal (flush=0, stall=0):
  - the chain shifts by one slot.
  - slot0 loads valid <= in_valid, data <= in_data.
  - slot0 ctrl <= in_ctrl if in_valid=1, else CTRL_SAFE. A bubble never carries live control.
- Latency: an input accepted at edge N appears at the outputs after edge N+STAGES-1. Stall cycles extend this one-for-one.
- STAGES outside 1..4 is a synthesis-time error (elaboration check).

Optional Feature:
- Macro PIPE_REG_PERF_EN.
- Defined:
  - stall_cnt increments on each edge with rst_n=1, stall=1, flush=0.
  - flush_cnt increments on each edge with rst_n=1, flush=1.
  - Both counters saturate at all-ones and do not wrap.
  - Both clear on reset.
- Undefined: the counter logic is absent, and stall_cnt/flush_cnt are driven constant 0. Datapath behaviour is identical either way.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, in_ctrl=16'hFFFF. Required: out_valid=0, out_ctrl=CTRL_SAFE (0), out_data=0; stall_cnt=flush_cnt=0.
- Streaming, STAGES=1: feed valid ctrl/data 16'h0011/…A1, 16'h0022/…A2, 16'h0033/…A3 on consecutive cycles. Required: each appears on out_* exactly one cycle later, with out_valid=1.
- Stall: with 16'h0022 in the register, assert stall for 3 cycles while in_ctrl changes. Required: out_ctrl stays 16'h0022 and out_valid stays 1; after release, next input appears on the following cycle.
- Flush+stall: assert flush and stall together with in_valid=1, in_ctrl=16'h00FF, in_data=X. Required: out_valid=0, out_ctrl=0 next cycle, out_data=X; with PERF, flush_cnt=1 and stall_cnt unchanged.
- Bubble gating: in_valid=0, in_ctrl=16'hBEEF. Required: out_ctrl=CTRL_SAFE and out_valid=0 next cycle.
- STAGES=3 with PIPE_REG_PERF_EN and CNT_W=2: latency is 3 edges. A flush with 3 items in flight kills all 3. Assert stall for 5 cycles; required: stall_cnt saturates at 3.
